// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan driver for a multiplexed 7-segment board: one shared segment bus, one-hot digit enables.
// Optional per-cycle PWM dimming of the active anode when SEG7_SCAN_BRIGHTNESS_EN is defined.
module seg7_scan_mux #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int SCAN_DIV        = 1024,
  parameter int BLANK_CYCLES    = 16,
  parameter int LED_LOGIC       = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic [NUM_OF_DISPLAYS-1:0][7:0] seg7_i,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  input  logic [3:0]                      brightness_i,
`endif
  output logic [7:0]                      seg_o,
  output logic [NUM_OF_DISPLAYS-1:0]      an_o,
  output logic                            frame_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_OF_DISPLAYS > 1) ? $clog2(NUM_OF_DISPLAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NUM_OF_DISPLAYS - 1);
  localparam logic             POL_INV    = (LED_LOGIC == 0);
  localparam logic [7:0]                 SEG_IDLE = {8{POL_INV}};
  localparam logic [NUM_OF_DISPLAYS-1:0] AN_IDLE  = {NUM_OF_DISPLAYS{POL_INV}};

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [NUM_OF_DISPLAYS-1:0][7:0]   snap_q, snap_d;
  logic                              frame_q, frame_d;
  logic [7:0]                        seg_q, seg_d;
  logic [NUM_OF_DISPLAYS-1:0]        an_q, an_d;
  logic                              frame_start;
  logic                              anode_on;
  logic [7:0]                        seg_raw;
  logic [NUM_OF_DISPLAYS-1:0]        an_raw;

  assign frame_start = en_i && (cnt_q == '0) && (idx_q == '0);

  // Slot counter, digit index, snapshot and frame pulse
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      frame_d = frame_start;
      if (frame_start) snap_d = seg7_i;
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      frame_q <= 1'b0;
      seg_q   <= SEG_IDLE;
      an_q    <= AN_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Next state: the blank window occupies the first BLANK_CYCLES counts of each slot
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
        ST_DRIVE: if (cnt_q == CNT_MAX)    state_d = ST_BLANK;
        default:  state_d = ST_BLANK;
      endcase
    end
  end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = '0;
    if (en_i && state_q == ST_DRIVE) pwm_d = pwm_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_q <= '0;
    else         pwm_q <= pwm_d;
  end

  assign anode_on = (brightness_i == 4'hF) || (pwm_q < brightness_i);
`else
  assign anode_on = 1'b1;
`endif

  // Outputs: en_i gates directly so a drop blanks the display on the very next edge
  always_comb begin
    seg_raw = '0;
    an_raw  = '0;
    if (en_i && state_q == ST_DRIVE) begin
      seg_raw        = snap_q[idx_q];
      an_raw[idx_q]  = anode_on;
    end
    seg_d = POL_INV ? ~seg_raw : seg_raw;
    an_d  = POL_INV ? ~an_raw  : an_raw;
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: reset, scan order, snapshot, enable toggle, wrap, async reset, and
// brightness PWM when SEG7_SCAN_BRIGHTNESS_EN is defined.
module tb_seg7_scan_mux;

  localparam int NUM = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [NUM-1:0][7:0] seg7;
  logic [7:0] hi_seg, lo_seg;
  logic [NUM-1:0] hi_an, lo_an;
  logic hi_frame, lo_frame;

  int n_tests = 0;
  int n_fail = 0;
  int k = 0;
  int frame_cnt = 0;
  int last_frame = 0;
  int multi_hot = 0;

  always #5 clk = ~clk;

`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [3:0] br_full = 4'hF;
  logic [3:0] br = 4'hF;
  logic [7:0] br_seg;
  logic [NUM-1:0] br_an;
  logic br_frame;

  seg7_scan_mux #(.NUM_OF_DISPLAYS(NUM), .SCAN_DIV(40), .BLANK_CYCLES(2), .LED_LOGIC(1)) u_br (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seg7_i(seg7), .brightness_i(br),
    .seg_o(br_seg), .an_o(br_an), .frame_o(br_frame));
`endif

  seg7_scan_mux #(.NUM_OF_DISPLAYS(NUM), .SCAN_DIV(8), .BLANK_CYCLES(2), .LED_LOGIC(1)) u_hi (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seg7_i(seg7),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    .brightness_i(br_full),
`endif
    .seg_o(hi_seg), .an_o(hi_an), .frame_o(hi_frame));

  seg7_scan_mux #(.NUM_OF_DISPLAYS(NUM), .SCAN_DIV(8), .BLANK_CYCLES(2), .LED_LOGIC(0)) u_lo (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seg7_i(seg7),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    .brightness_i(br_full),
`endif
    .seg_o(lo_seg), .an_o(lo_an), .frame_o(lo_frame));

  typedef struct {
    int             k;
    logic [NUM-1:0] an;
    logic [7:0]     seg;
    logic           frame;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    if ($countones(hi_an) > 1) multi_hot++;
  endtask

  task automatic check_dark(input string name);
    check({name, " hi"}, {hi_frame, hi_an, hi_seg}, {1'b0, 6'h00, 8'h00});
    check({name, " lo"}, {lo_an, lo_seg}, {6'h3F, 8'hFF});
  endtask

  // Closed-form expectation for the 8-cycle-slot instances: 2 dark cycles then 6 driven cycles per slot
  task automatic sweep_check();
    int pos, d, f;
    logic [NUM-1:0] e_an;
    logic [7:0] e_seg;
    logic e_frame;
    pos = (k - 1) % 8;
    d = ((k - 1) / 8) % NUM;
    f = (k - 1) / 48;
    e_an = '0;
    e_seg = '0;
    if (pos >= 2) begin
      e_an[d] = 1'b1;
      e_seg = (d == 3 && f >= 1) ? 8'hAA : 8'(8'h10 + d);
    end
    e_frame = ((k - 1) % 48 == 0);
    check($sformatf("scan k=%0d", k), {hi_frame, hi_an, hi_seg}, {e_frame, e_an, e_seg});
    check($sformatf("scan_lo k=%0d", k), {lo_an, lo_seg}, {~e_an, ~e_seg});
  endtask

  initial begin
    tbl[0]  = '{1,  6'h00, 8'h00, 1'b1};
    tbl[1]  = '{2,  6'h00, 8'h00, 1'b0};
    tbl[2]  = '{3,  6'h01, 8'h10, 1'b0};
    tbl[3]  = '{8,  6'h01, 8'h10, 1'b0};
    tbl[4]  = '{9,  6'h00, 8'h00, 1'b0};
    tbl[5]  = '{11, 6'h02, 8'h11, 1'b0};
    tbl[6]  = '{27, 6'h08, 8'h13, 1'b0};
    tbl[7]  = '{32, 6'h08, 8'h13, 1'b0};
    tbl[8]  = '{43, 6'h20, 8'h15, 1'b0};
    tbl[9]  = '{48, 6'h20, 8'h15, 1'b0};
    tbl[10] = '{49, 6'h00, 8'h00, 1'b1};
    tbl[11] = '{50, 6'h00, 8'h00, 1'b0};
    tbl[12] = '{51, 6'h01, 8'h10, 1'b0};
    tbl[13] = '{75, 6'h08, 8'hAA, 1'b0};
    tbl[14] = '{96, 6'h20, 8'h15, 1'b0};
    tbl[15] = '{97, 6'h00, 8'h00, 1'b1};
    tbl[16] = '{98, 6'h00, 8'h00, 1'b0};
    tbl[17] = '{99, 6'h01, 8'h10, 1'b0};

    for (int i = 0; i < NUM; i++) seg7[i] = 8'(8'h10 + i);
    en = 1'b1;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset hi", {hi_frame, hi_an, hi_seg}, {1'b0, 6'h00, 8'h00});
    check("reset lo", {lo_frame, lo_an, lo_seg}, {1'b0, 6'h3F, 8'hFF});

    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 180; c++) begin
      tick();
      if (k == 12) seg7[3] = 8'hAA;
      sweep_check();
      foreach (tbl[i]) begin
        if (tbl[i].k == k)
          check($sformatf("vec k=%0d", k), {hi_frame, hi_an, hi_seg},
                {tbl[i].frame, tbl[i].an, tbl[i].seg});
      end
      if (hi_frame) begin
        frame_cnt++;
        if (last_frame > 0) check($sformatf("frame gap k=%0d", k), k - last_frame, 48);
        last_frame = k;
      end
      if (k == 144) check("frames in 3*48", frame_cnt, 3);
    end

    // en_i dropped during digit 4 DRIVE; new pattern loaded for the fresh snapshot
    check("pre-drop digit4", {hi_an, hi_seg}, {6'h10, 8'h14});
    en = 1'b0;
    seg7[0] = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_dark($sformatf("en low k=%0d", k));
    end
    en = 1'b1;
    tick();
    check("reenable frame", {hi_frame, hi_an, hi_seg}, {1'b1, 6'h00, 8'h00});
    tick();
    check("reenable blank", {hi_frame, hi_an, hi_seg}, {1'b0, 6'h00, 8'h00});
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("reenable d0 k=%0d", k), {hi_frame, hi_an, hi_seg}, {1'b0, 6'h01, 8'h5A});
    end
    tick();
    check("reenable d1 blank", {hi_an, hi_seg}, {6'h00, 8'h00});
    tick();
    tick();
    check("reenable d1 drive", {hi_an, hi_seg}, {6'h02, 8'h11});

    // Asynchronous reset mid-DRIVE, well away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset hi", {hi_frame, hi_an, hi_seg}, {1'b0, 6'h00, 8'h00});
    check("async reset lo", {lo_frame, lo_an, lo_seg}, {1'b0, 6'h3F, 8'hFF});
    check("no multi-hot", multi_hot, 0);

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    @(posedge clk);
    #1;
    br = 4'd4;
    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 120; c++) begin
      int pos, d, bv;
      logic [NUM-1:0] e_an;
      logic [7:0] e_seg;
      tick();
      pos = (k - 1) % 40;
      d = (k - 1) / 40;
      bv = (d == 0) ? 4 : (d == 1) ? 0 : 15;
      e_an = '0;
      e_seg = '0;
      if (pos >= 2) begin
        e_seg = seg7[d];
        if (bv == 15 || ((pos - 2) % 16) < bv) e_an[d] = 1'b1;
      end
      check($sformatf("bright k=%0d", k), {br_an, br_seg}, {e_an, e_seg});
      if (k == 40) br = 4'd0;
      if (k == 80) br = 4'd15;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
